// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared types and default sizing for the quick-sort storage responder.
//   state_e          : init-sweep FSM states
//   DEF_WORD_SIZE    : default data/address width
//   DEF_DEPTH        : default number of stored words
// Optional feature macro: REG_FILE_INIT_SWEEP_EN (see reg_file_init_ctrl).
package reg_file_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam int unsigned DEF_WORD_SIZE = 16;
   localparam int unsigned DEF_DEPTH     = 64;

   // Pointer width able to address every word, never narrower than one bit.
   function automatic int unsigned addr_bits(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if
// Request/response bundle between the sort controllers and reg_file.
//   reg_addr, reg_in           : request address and write data (master -> slave)
//   reg_READ_EN, reg_WRITE_EN  : read / write request strobes     (master -> slave)
//   err_clr                    : clears the sticky addr_err       (master -> slave)
//   reg_out                    : combinational read data          (slave -> master)
//   mem_ready                  : requests are being serviced      (slave -> master)
//   addr_err                   : sticky out-of-range flag         (slave -> master)
interface reg_file_if #(
   parameter int unsigned WORD_SIZE = 16
);

   logic [WORD_SIZE-1:0] reg_addr;
   logic [WORD_SIZE-1:0] reg_in;
   logic                 reg_READ_EN;
   logic                 reg_WRITE_EN;
   logic                 err_clr;
   logic [WORD_SIZE-1:0] reg_out;
   logic                 mem_ready;
   logic                 addr_err;

   modport master (
      output reg_addr, reg_in, reg_READ_EN, reg_WRITE_EN, err_clr,
      input  reg_out, mem_ready, addr_err
   );

   modport slave (
      input  reg_addr, reg_in, reg_READ_EN, reg_WRITE_EN, err_clr,
      output reg_out, mem_ready, addr_err
   );

endinterface

// File: rtl/reg_file_init_ctrl.sv
// reg_file_init_ctrl
// Post-reset clear sweep: writes zero to every word, then reports ready.
//   clk, rst_n  : clock, asynchronous active-low reset
//   init_we     : clear-write strobe for the array
//   init_addr   : word being cleared
//   mem_ready   : high once requests may be serviced
// With REG_FILE_INIT_SWEEP_EN undefined the sweep and pointer are absent and
// the FSM comes out of reset already in ST_READY.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   ST_INIT  | clearing mem[ptr] each cycle, requests ignored
//   ST_READY | sweep done, requests serviced
module reg_file_init_ctrl
   import reg_file_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   localparam int unsigned AW   = addr_bits(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          init_we,
   output logic [AW-1:0] init_addr,
   output logic          mem_ready
);

   state_e state_q, state_d;

`ifdef REG_FILE_INIT_SWEEP_EN

   logic [AW-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      init_we   = 1'b0;
      init_addr = ptr_q;
      case (state_q)
         ST_INIT: begin
            init_we = 1'b1;
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = ST_READY;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
         end
      endcase
   end

`else

   // No sweep: the state register only ever holds ST_READY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_READY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = ST_READY;
      init_we   = 1'b0;
      init_addr = '0;
   end

`endif

   assign mem_ready = (state_q == ST_READY);

endmodule

// File: rtl/reg_file.sv
// reg_file
// Word-addressable storage for the quick-sort datapath. Services one
// read/write request per cycle once the init controller reports ready,
// with zero-latency reads and a sticky out-of-range flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_file_if slave (address, data, enables, err_clr,
//                reg_out, mem_ready, addr_err)
// Optional feature macro: REG_FILE_INIT_SWEEP_EN enables the post-reset
// clear sweep; without it memory contents after reset are undefined.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   localparam int unsigned AW       = addr_bits(DEPTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   reg_file_if.slave  bus
);

   logic [WORD_SIZE-1:0] mem_q [DEPTH];

   logic                 init_we;
   logic [AW-1:0]        init_addr;
   logic                 mem_ready;

   logic                 addr_in_range;
   logic [AW-1:0]        req_idx;
   logic                 svc_ok;
   logic                 req_any;

   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [WORD_SIZE-1:0] wr_data;

   logic                 addr_err_q, addr_err_d;

   reg_file_init_ctrl #(
      .DEPTH (DEPTH)
   ) u_init_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_we   (init_we),
      .init_addr (init_addr),
      .mem_ready (mem_ready)
   );

   // Full-width compare so aliased upper address bits are still rejected.
   assign addr_in_range = (bus.reg_addr < WORD_SIZE'(DEPTH));
   assign req_idx       = bus.reg_addr[AW-1:0];
   // Gating with rst_n keeps a request from landing on the release edge even
   // when the block is ready straight out of reset.
   assign svc_ok        = mem_ready & rst_n;
   assign req_any       = bus.reg_READ_EN | bus.reg_WRITE_EN;

   // Single write port shared by the clear sweep and requests.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = init_addr;
      wr_data = '0;
      if (init_we) begin
         wr_en = 1'b1;
      end else if (svc_ok && bus.reg_WRITE_EN && addr_in_range) begin
         wr_en   = 1'b1;
         wr_addr = req_idx;
         wr_data = bus.reg_in;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      bus.reg_out = '0;
      if (svc_ok && bus.reg_READ_EN && addr_in_range) begin
         bus.reg_out = mem_q[req_idx];
      end
   end

   // Set has priority over clear when both land on the same edge.
   always_comb begin
      addr_err_d = addr_err_q;
      if (svc_ok && req_any && !addr_in_range) begin
         addr_err_d = 1'b1;
      end else if (bus.err_clr) begin
         addr_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign bus.mem_ready = mem_ready;
   assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
// Self-checking bench for reg_file. Read expectations come from a reference
// array updated as writes are driven; they are queued at drive time and
// compared against reg_out within the same cycle. Builds with or without
// REG_FILE_INIT_SWEEP_EN.
module tb_reg_file;
   import reg_file_pkg::*;

   localparam int unsigned WS = DEF_WORD_SIZE;
   localparam int unsigned DP = DEF_DEPTH;
   localparam int unsigned AW = addr_bits(DP);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   reg_file_if #(.WORD_SIZE(WS)) bus ();

   reg_file #(
      .WORD_SIZE (WS),
      .DEPTH     (DP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      string         tag;
      logic [WS-1:0] exp;
   } sb_t;

   sb_t           sb_q[$];
   logic [WS-1:0] mdl [DP];
   logic          mdl_err;
   logic          ready_exp;
   int            n_chk  = 0;
   int            n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle_inputs();
      bus.reg_addr     = '0;
      bus.reg_in       = '0;
      bus.reg_READ_EN  = 1'b0;
      bus.reg_WRITE_EN = 1'b0;
      bus.err_clr      = 1'b0;
   endtask

   // One request cycle: drive after the falling edge, check reg_out before
   // the rising edge, then check addr_err just after it.
   task automatic drive(input string tag, input logic [WS-1:0] a, input logic [WS-1:0] d,
                        input logic re, input logic we, input logic clr);
      sb_t  e;
      logic inr;
      inr = (a < WS'(DP));
      @(negedge clk);
      bus.reg_addr     = a;
      bus.reg_in       = d;
      bus.reg_READ_EN  = re;
      bus.reg_WRITE_EN = we;
      bus.err_clr      = clr;
      if (re) begin
         e.tag = tag;
         e.exp = (inr && ready_exp) ? mdl[a[AW-1:0]] : '0;
         sb_q.push_back(e);
      end
      #1;
      if (re && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.tag, 32'(bus.reg_out), 32'(e.exp));
      end
      @(posedge clk);
      if (ready_exp && we && inr) mdl[a[AW-1:0]] = d;
      if (ready_exp && (re || we) && !inr) mdl_err = 1'b1;
      else if (clr) mdl_err = 1'b0;
      #1;
      check({tag, "_err"}, 32'(bus.addr_err), 32'(mdl_err));
      idle_inputs();
   endtask

   task automatic wait_ready(input string tag);
      int cnt;
      cnt = 0;
      while (cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
         if (bus.mem_ready) break;
      end
      idle_inputs();
      check(tag, 32'(cnt), 32'(DP));
      ready_exp = 1'b1;
      for (int i = 0; i < int'(DP); i++) mdl[i] = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [WS-1:0] va, vb;
      idle_inputs();
      ready_exp = 1'b0;
      mdl_err   = 1'b0;
      rst_n     = 1'b0;
      #12;
`ifdef REG_FILE_INIT_SWEEP_EN
      check("rst_ready", 32'(bus.mem_ready), 32'd0);
`else
      check("rst_ready", 32'(bus.mem_ready), 32'd1);
`endif
      check("rst_err", 32'(bus.addr_err), 32'd0);
      bus.reg_READ_EN = 1'b1;
      #1;
      check("rst_out", 32'(bus.reg_out), 32'd0);
      idle_inputs();

      @(negedge clk);
      rst_n = 1'b1;
`ifdef REG_FILE_INIT_SWEEP_EN
      // A write held through the sweep must be ignored.
      bus.reg_addr     = '0;
      bus.reg_in       = 16'hDEAD;
      bus.reg_WRITE_EN = 1'b1;
      wait_ready("sweep_len");
      check("sweep_err", 32'(bus.addr_err), 32'd0);
      drive("rd0",  16'd0,  '0, 1'b1, 1'b0, 1'b0);
      drive("rd31", 16'd31, '0, 1'b1, 1'b0, 1'b0);
      drive("rd63", 16'd63, '0, 1'b1, 1'b0, 1'b0);
`else
      ready_exp = 1'b1;
      #1;
      check("nosweep_ready", 32'(bus.mem_ready), 32'd1);
      drive("wr3", 16'd3, 16'hABCD, 1'b0, 1'b1, 1'b0);
      drive("rd3", 16'd3, '0, 1'b1, 1'b0, 1'b0);
      drive("wr0", 16'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
`endif

      drive("wr5", 16'd5, 16'h1234, 1'b0, 1'b1, 1'b0);
      drive("rd5", 16'd5, '0, 1'b1, 1'b0, 1'b0);

      // Swap [7] and [12] using the read values as the controller would.
      drive("pre7",  16'd7,  16'd9, 1'b0, 1'b1, 1'b0);
      drive("pre12", 16'd12, 16'd3, 1'b0, 1'b1, 1'b0);
      va = mdl[7];
      vb = mdl[12];
      drive("swp_ra", 16'd7,  '0, 1'b1, 1'b0, 1'b0);
      drive("swp_rb", 16'd12, '0, 1'b1, 1'b0, 1'b0);
      drive("swp_wa", 16'd7,  vb, 1'b0, 1'b1, 1'b0);
      drive("swp_wb", 16'd12, va, 1'b0, 1'b1, 1'b0);
      drive("post7",  16'd7,  '0, 1'b1, 1'b0, 1'b0);
      check("swap7",  32'(mdl[7]),  32'd3);
      drive("post12", 16'd12, '0, 1'b1, 1'b0, 1'b0);
      check("swap12", 32'(mdl[12]), 32'd9);

      // Read+write together: old data before the edge, new data after.
      drive("wr20", 16'd20, 16'h00AA, 1'b0, 1'b1, 1'b0);
      drive("rw20", 16'd20, 16'h0055, 1'b1, 1'b1, 1'b0);
      drive("rd20", 16'd20, '0, 1'b1, 1'b0, 1'b0);

      // Top boundary is in range.
      drive("wr63", 16'd63, 16'hBEEF, 1'b0, 1'b1, 1'b0);
      drive("rd63b", 16'd63, '0, 1'b1, 1'b0, 1'b0);

      // Out-of-range: 64 aliases word 0, 0x1005 aliases word 5.
      drive("wr64", 16'd64, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      drive("rd0b", 16'd0, '0, 1'b1, 1'b0, 1'b0);
      drive("wr1005", 16'h1005, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      drive("rd5b", 16'd5, '0, 1'b1, 1'b0, 1'b0);
      drive("rd64", 16'd64, '0, 1'b1, 1'b0, 1'b0);
      drive("clr_bad", 16'hFFFF, '0, 1'b1, 1'b0, 1'b1);
      check("err_sticky", 32'(bus.addr_err), 32'd1);
      drive("clr_only", 16'd0, '0, 1'b0, 1'b0, 1'b1);
      check("err_cleared", 32'(bus.addr_err), 32'd0);
      drive("rd_ok", 16'd12, '0, 1'b1, 1'b0, 1'b0);

      drive("wr40", 16'd40, 16'h0077, 1'b0, 1'b1, 1'b0);
      drive("rd40", 16'd40, '0, 1'b1, 1'b0, 1'b0);

      // Reset again, interrupt the sweep at cycle 20, then sweep fully.
      @(negedge clk);
      rst_n     = 1'b0;
      ready_exp = 1'b0;
      mdl_err   = 1'b0;
      #2;
      check("rst2_err", 32'(bus.addr_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef REG_FILE_INIT_SWEEP_EN
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("resweep_len");
      drive("rd40_clr", 16'd40, '0, 1'b1, 1'b0, 1'b0);
      drive("rd5_clr",  16'd5,  '0, 1'b1, 1'b0, 1'b0);
`else
      ready_exp = 1'b1;
      #1;
      check("rst2_ready", 32'(bus.mem_ready), 32'd1);
      drive("wr3b", 16'd3, 16'h0F0F, 1'b0, 1'b1, 1'b0);
      drive("rd3b", 16'd3, '0, 1'b1, 1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
